// File: rtl/cpu4_pkg.sv
// cpu4_pkg: opcode map, ALU select codes, sequencer states and decode record for the 4-bit CPU
package cpu4_pkg;
  localparam logic [3:0] OP_HLT = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_STO = 4'h3,
                         OP_LD  = 4'h4, OP_B   = 4'h5, OP_BZ  = 4'h6, OP_LDV = 4'h7,
                         OP_INP = 4'h8, OP_OUT = 4'h9, OP_AND = 4'hA, OP_OR  = 4'hB,
                         OP_NOT = 4'hC;
  localparam logic [3:0] S_ADD = 4'b1001, S_SUB = 4'b0110, S_PASSA = 4'b0000,
                         S_PASSB = 4'b1010, S_AND = 4'b1110, S_OR = 4'b1011, S_NOT = 4'b0000;
  localparam logic [1:0] ALUB_RAM = 2'd0, ALUB_IMM = 2'd1, ALUB_INP = 2'd2;
  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_HALT, ST_LOAD} state_t;
  typedef struct packed {
    logic [3:0] alu_s;
    logic       alu_m;
    logic       alu_cn;
    logic [1:0] alub_sel;
    logic       writes_acc;
    logic       is_sto;
    logic       is_out;
    logic       is_b;
    logic       is_bz;
    logic       is_hlt;
  } dec_t;
endpackage

// File: rtl/cpu4_op_decode.sv
// cpu4_op_decode: combinational opcode to ALU controls and instruction class flags
module cpu4_op_decode
  import cpu4_pkg::*;
(
  input  logic [3:0] op,
  output dec_t       dec
);
  always_comb begin
    dec = '0;
    case (op)
      OP_ADD:                {dec.alu_s, dec.alu_m, dec.alu_cn} = {S_ADD, 2'b00};
      OP_SUB:                {dec.alu_s, dec.alu_m, dec.alu_cn} = {S_SUB, 2'b01};
      OP_STO, OP_OUT:        {dec.alu_s, dec.alu_m, dec.alu_cn} = {S_PASSA, 2'b01};
      OP_LD, OP_LDV, OP_INP: {dec.alu_s, dec.alu_m, dec.alu_cn} = {S_PASSB, 2'b10};
      OP_AND:                {dec.alu_s, dec.alu_m, dec.alu_cn} = {S_AND, 2'b10};
      OP_OR:                 {dec.alu_s, dec.alu_m, dec.alu_cn} = {S_OR, 2'b10};
      OP_NOT:                {dec.alu_s, dec.alu_m, dec.alu_cn} = {S_NOT, 2'b10};
      default: ;
    endcase
    dec.alub_sel   = op == OP_LDV ? ALUB_IMM : op == OP_INP ? ALUB_INP : ALUB_RAM;
    dec.writes_acc = op inside {OP_ADD, OP_SUB, OP_LD, OP_LDV, OP_INP, OP_AND, OP_OR, OP_NOT};
    dec.is_sto     = op == OP_STO;
    dec.is_out     = op == OP_OUT;
    dec.is_b       = op == OP_B;
    dec.is_bz      = op == OP_BZ;
    dec.is_hlt     = op == OP_HLT;
  end
endmodule

// File: rtl/cpu4_sequencer.sv
// cpu4_sequencer: FETCH/DECODE/EXEC/WB control FSM, program-RAM arbitration and retired counter
module cpu4_sequencer
  import cpu4_pkg::*;
#(
  parameter int OPC_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             load_req,
  output logic             load_gnt,
  input  logic [OPC_W-1:0] opcode,
  input  logic             acc_zero,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cn,
  output logic [1:0]       alub_sel,
  output logic             alureg_we,
  output logic             acc_we,
  output logic             ram_we,
  output logic             out_we,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  state_t     state, state_nx;
  logic [3:0] op_q;
  dec_t       dec;
  logic       act, in_alu, taken;

  cpu4_op_decode u_dec (.op(op_q), .dec(dec));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      retired <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_FETCH) op_q <= opcode[3:0];
      if (state == ST_WB || (state == ST_EXEC && dec.is_hlt)) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   state_nx = load_req ? ST_LOAD : (run || step) ? ST_FETCH : ST_IDLE;
      ST_FETCH:  state_nx = ST_DECODE;
      ST_DECODE: state_nx = ST_EXEC;
      ST_EXEC:   state_nx = dec.is_hlt ? ST_HALT : ST_WB;
      ST_WB:     state_nx = (run && !load_req) ? ST_FETCH : ST_IDLE;
      ST_HALT:   state_nx = load_req ? ST_LOAD : ST_HALT;
      ST_LOAD:   state_nx = load_req ? ST_LOAD : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // strobes are masked while reset is high so an interrupted instruction never writes
  assign act       = !reset;
  assign in_alu    = act && (state inside {ST_DECODE, ST_EXEC, ST_WB});
  assign taken     = dec.is_b || (dec.is_bz && acc_zero);
  assign alu_s     = in_alu ? dec.alu_s : '0;
  assign alu_m     = in_alu && dec.alu_m;
  assign alu_cn    = in_alu && dec.alu_cn;
  assign alub_sel  = in_alu ? dec.alub_sel : ALUB_RAM;
  assign ir_load   = act && state == ST_FETCH;
  assign alureg_we = act && state == ST_EXEC && dec.writes_acc;
  assign ram_we    = act && state == ST_EXEC && dec.is_sto;
  assign out_we    = act && state == ST_EXEC && dec.is_out;
  assign acc_we    = act && state == ST_WB && dec.writes_acc;
  assign pc_load   = act && state == ST_WB && taken;
  assign pc_inc    = act && state == ST_WB && !taken;
  assign halted    = act && state == ST_HALT;
  assign load_gnt  = act && state == ST_LOAD;
endmodule

// File: tb/tb_cpu4_sequencer.sv
// tb_cpu4_sequencer: scoreboard bench; program-level reference model predicts each instruction's strobes
module tb_cpu4_sequencer;
  logic clk = 0, reset = 1, run = 0, step = 0, load_req = 0;
  logic load_gnt, acc_zero, ir_load, pc_inc, pc_load, alu_m, alu_cn;
  logic alureg_we, acc_we, ram_we, out_we, halted;
  logic [3:0] opcode, alu_s;
  logic [1:0] alub_sel;
  logic [7:0] retired;
  logic [24:0] outs;

  logic [3:0] prog [16];
  logic       az   [16];
  logic [3:0] tgt  [16];
  logic [3:0] pc_env;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] alu;
    logic [2:0] ex;
    logic [2:0] wb;
    logic       hlt;
    logic [7:0] ret;
  } exp_t;
  exp_t sbq[$];

  int n_chk = 0, n_fail = 0;
  logic [3:0] m_pc;
  logic [7:0] m_ret;

  cpu4_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .load_req(load_req),
    .load_gnt(load_gnt), .opcode(opcode), .acc_zero(acc_zero), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn),
    .alub_sel(alub_sel), .alureg_we(alureg_we), .acc_we(acc_we), .ram_we(ram_we),
    .out_we(out_we), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  assign outs = {load_gnt, ir_load, pc_inc, pc_load, alu_s, alu_m, alu_cn, alub_sel,
                 alureg_we, acc_we, ram_we, out_we, halted, retired};

  // program RAM and PC live in the bench; the DUT only steers the PC
  assign opcode   = prog[pc_env];
  assign acc_zero = az[pc_env];
  always @(posedge clk)
    if (reset) pc_env <= 4'd0;
    else if (pc_load) pc_env <= tgt[pc_env];
    else if (pc_inc) pc_env <= pc_env + 4'd1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic a0, input logic [7:0] ret);
    exp_t e;
    logic wa, tk;
    e.op = op;
    case (op)
      4'h1:       e.alu = 8'b1001_0_0_00;
      4'h2:       e.alu = 8'b0110_0_1_00;
      4'h3, 4'h9: e.alu = 8'b0000_0_1_00;
      4'h4:       e.alu = 8'b1010_1_0_00;
      4'h7:       e.alu = 8'b1010_1_0_01;
      4'h8:       e.alu = 8'b1010_1_0_10;
      4'hA:       e.alu = 8'b1110_1_0_00;
      4'hB:       e.alu = 8'b1011_1_0_00;
      4'hC:       e.alu = 8'b0000_1_0_00;
      default:    e.alu = 8'h00;
    endcase
    wa    = op inside {4'h1, 4'h2, 4'h4, 4'h7, 4'h8, 4'hA, 4'hB, 4'hC};
    tk    = op == 4'h5 || (op == 4'h6 && a0);
    e.ex  = {wa, op == 4'h3, op == 4'h9};
    e.wb  = op == 4'h0 ? 3'b000 : {wa, !tk, tk};
    e.hlt = op == 4'h0;
    e.ret = op == 4'h0 ? ret + 8'd1 : ret;
    return e;
  endfunction

  task automatic predict(input int k, output int n);
    exp_t e;
    n = 0;
    while (n < k) begin
      e = model(prog[m_pc], az[m_pc], m_ret);
      sbq.push_back(e);
      n++;
      m_ret++;
      if (e.hlt) break;
      m_pc = e.wb[0] ? tgt[m_pc] : m_pc + 4'd1;
    end
  endtask

  // monitor: tracks each instruction from ir_load and compares against the scoreboard
  int age;
  logic busy = 0, stray, alu_chg;
  logic [7:0] alu0;
  logic [2:0] ex_seen, exv, wbv;
  exp_t got_e;
  always @(negedge clk) begin
    exv = {alureg_we, ram_we, out_we};
    wbv = {acc_we, pc_inc, pc_load};
    chk("one_write", 32'($countones(exv) <= 1), 1);
    chk("inc_and_load", 32'(pc_inc && pc_load), 0);
    if (reset) busy = 0;
    else if (busy) begin
      age++;
      if (ir_load) stray = 1;
      if (age == 1) begin
        alu0 = {alu_s, alu_m, alu_cn, alub_sel};
        if (|exv || |wbv) stray = 1;
      end else if ({alu_s, alu_m, alu_cn, alub_sel} != alu0) alu_chg = 1;
      if (age == 2) begin
        ex_seen = exv;
        if (|wbv) stray = 1;
      end
      if (age == 3) begin
        if (|exv) stray = 1;
        chk("sb_nonempty", 32'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          got_e = sbq.pop_front();
          chk("alu_ctrl", alu0, got_e.alu);
          chk("alu_hold", alu_chg, 0);
          chk("exec_we", ex_seen, got_e.ex);
          chk("wb_we", wbv, got_e.wb);
          chk("halted", halted, got_e.hlt);
          chk("retired", retired, got_e.ret);
          chk("stray_strobe", stray, 0);
        end
        busy = 0;
      end
    end else if (ir_load) begin
      busy = 1; age = 0; stray = 0; alu_chg = 0;
    end else chk("idle_strobe", {exv, wbv}, 0);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1; run = 0; step = 0; load_req = 0;
    repeat (2) @(negedge clk);
    reset = 0; m_pc = 0; m_ret = 0;
  endtask

  task automatic run_n(input int n);
    int seen = 0, b = 0;
    run = 1;
    while (seen < n && b < 400 && !halted) begin
      @(negedge clk);
      b++;
      if (ir_load) seen++;
    end
    run = 0;
    chk("run_budget", 32'(b < 400), 1);
    repeat (6) @(negedge clk);
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); step = 1;
      @(negedge clk); step = 0;
      @(negedge clk); step = ($urandom_range(0, 1) == 1);
      @(negedge clk); step = 0;
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    int n, b, cnt, fet;
    logic bad;
    for (int i = 0; i < 16; i++) begin prog[i] = 4'hD; az[i] = 0; tgt[i] = 0; end

    // ADD: reset state and four-cycle timing
    prog[0] = 4'h1;
    do_reset();
    #1 chk("reset_outs", outs, 0);
    predict(1, n);
    run = 1;
    @(negedge clk) chk("t1_irload_c1", ir_load, 1);
    run = 0;
    @(negedge clk) chk("t1_alu_c2", {alu_s, alu_m, alu_cn}, 6'b1001_0_0);
    @(negedge clk) chk("t1_alureg_c3", alureg_we, 1);
    @(negedge clk) chk("t1_acc_inc_c4", {acc_we, pc_inc, pc_load}, 3'b110);
    @(negedge clk) chk("t1_retired", retired, 1);

    // BZ taken then not taken
    prog[0] = 4'h6; az[0] = 1; tgt[0] = 4'd5; prog[5] = 4'h6; az[5] = 0;
    do_reset();
    predict(2, n);
    run_n(n);
    chk("t2_pc", pc_env, 6);

    // HLT, run ignored, loader handshake
    prog[0] = 4'h0;
    do_reset();
    predict(1, n);
    run = 1; b = 0;
    while (!halted && b < 20) begin @(negedge clk); b++; end
    chk("t3_halt_seen", halted, 1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      step = ~step;
      if (ir_load || !halted) bad = 1;
    end
    step = 0;
    chk("t3_run_ignored", bad, 0);
    chk("t3_retired", retired, 1);
    load_req = 1;
    @(negedge clk) chk("t3_gnt", load_gnt, 1);
    run = 0; load_req = 0;
    @(negedge clk) chk("t3_release", {load_gnt, halted, ir_load}, 0);
    chk("t3_pc_kept", pc_env, 0);
    predict(1, n);
    run_n(n);

    // single step STO, mid-instruction step dropped
    prog[0] = 4'h3;
    do_reset();
    predict(1, n);
    @(negedge clk) step = 1;
    @(negedge clk) step = 0;
    chk("t4_fetch", ir_load, 1);
    @(negedge clk) step = 1;
    cnt = 0; fet = 0;
    repeat (8) begin
      @(negedge clk);
      step = 0;
      cnt += 32'(ram_we);
      fet += 32'(ir_load);
    end
    chk("t4_ram_we_once", cnt, 1);
    chk("t4_step_dropped", fet, 0);
    chk("t4_retired", retired, 1);

    // load_req beats run in IDLE; mid-instruction request waits for WB
    prog[0] = 4'h1;
    do_reset();
    run = 1; load_req = 1;
    @(negedge clk) chk("t5_load_wins", {load_gnt, ir_load}, 2'b10);
    predict(1, n);
    load_req = 0; b = 0;
    do begin @(negedge clk); b++; end while (!ir_load && b < 10);
    chk("t5_fetch", ir_load, 1);
    load_req = 1; bad = 0;
    repeat (3) begin @(negedge clk); bad |= load_gnt; end
    chk("t5_no_gnt_mid", bad, 0);
    repeat (2) @(negedge clk);
    chk("t5_gnt_after_wb", load_gnt, 1);
    chk("t5_retired", retired, 1);
    run = 0; load_req = 0;
    repeat (2) @(negedge clk);

    // reset during EXEC of OUT
    prog[0] = 4'h9;
    do_reset();
    run = 1; b = 0;
    do begin @(negedge clk); b++; end while (!ir_load && b < 10);
    run = 0;
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1;
    #1 chk("t6_outs_in_reset", outs[24:8], 0);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk) chk("t6_after_reset", outs, 0);
    m_pc = 0; m_ret = 0;

    // random programs, alternating free-run and single-step
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) begin
        prog[i] = 4'($urandom_range(0, 15));
        if (prog[i] == 4'h0 && $urandom_range(0, 3) != 0) prog[i] = 4'h2;
        az[i]  = ($urandom_range(0, 1) == 1);
        tgt[i] = 4'($urandom_range(0, 15));
      end
      do_reset();
      predict(24, n);
      if (r % 2 == 0) run_n(n);
      else step_n(n);
    end

    repeat (4) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
